// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared FSM state encoding and index-width helper for the arbiter
package wb_arbiter_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/wb_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, req[NM]+last in, first requester after last out as valid/idx
module rr_pick
  import wb_arbiter_pkg::*;
#(
  parameter int NM = 2,
  parameter int OW = idx_w(NM)
) (
  input  logic [NM-1:0] req,
  input  logic [OW-1:0] last,
  output logic          valid,
  output logic [OW-1:0] idx
);
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = NM; k >= 1; k--) begin
      if (req[(int'(last) + k) % NM]) begin
        valid = 1'b1;
        idx   = OW'((int'(last) + k) % NM);
      end
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: NM-master round-robin Wishbone arbiter with watchdog; clk_i/rst_i, m_* master side, s_* shared slave side
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NM  = 2,
  parameter int AW  = 2,
  parameter int DW  = 32,
  parameter int TMO = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NM-1:0]         m_cyc_i,
  input  logic [NM-1:0]         m_stb_i,
  input  logic [NM-1:0]         m_we_i,
  input  logic [NM*AW-1:0]      m_adr_i,
  input  logic [NM*DW-1:0]      m_dat_i,
  input  logic [NM*(DW/8)-1:0]  m_sel_i,
  output logic [NM-1:0]         m_ack_o,
  output logic [NM-1:0]         m_err_o,
  output logic [DW-1:0]         m_dat_o,
  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [AW-1:0]         s_adr_o,
  output logic [DW-1:0]         s_dat_o,
  output logic [DW/8-1:0]       s_sel_o,
  input  logic                  s_ack_i,
  input  logic [DW-1:0]         s_dat_i
);
  localparam int COLS = DW / 8;
  localparam int OW   = idx_w(NM);
  localparam int WW   = TMO > 1 ? $clog2(TMO) : 1;
  state_t          state;
  logic [OW-1:0]   owner, last, pick_idx;
  logic [WW-1:0]   wdog;
  logic [NM-1:0]   lock;
  logic            busy, pick_valid, tmo_hit;
  rr_pick #(.NM(NM), .OW(OW)) u_pick (
    .req  (m_cyc_i & ~lock),
    .last (last),
    .valid(pick_valid),
    .idx  (pick_idx)
  );
  // reset gates the slave side immediately so a mid-transaction reset forwards nothing
  assign busy    = state == ST_BUSY && !rst_i;
  assign s_cyc_o = busy;
  assign s_stb_o = busy && m_cyc_i[owner] && m_stb_i[owner];
  assign s_we_o  = busy && m_we_i[owner];
  assign s_adr_o = busy ? m_adr_i[int'(owner)*AW +: AW] : '0;
  assign s_dat_o = busy ? m_dat_i[int'(owner)*DW +: DW] : '0;
  assign s_sel_o = busy ? m_sel_i[int'(owner)*COLS +: COLS] : '0;
  assign m_dat_o = s_dat_i;
  // an ack in the final watchdog cycle suppresses the timeout
  assign tmo_hit = TMO > 0 && s_stb_o && !s_ack_i && wdog == WW'(TMO - 1);
  assign m_ack_o = busy && s_ack_i ? NM'(1) << owner : '0;
  assign m_err_o = tmo_hit ? NM'(1) << owner : '0;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      owner <= '0;
      last  <= OW'(NM - 1);
      wdog  <= '0;
      lock  <= '0;
    end else begin
      // a timed-out master stays locked out until its cyc is seen low
      lock <= (lock & m_cyc_i) | m_err_o;
      if (state == ST_IDLE) begin
        wdog <= '0;
        if (pick_valid) begin
          state <= ST_BUSY;
          owner <= pick_idx;
        end
      end else if (!m_cyc_i[owner] || tmo_hit) begin
        state <= ST_IDLE;
        last  <= owner;
        wdog  <= '0;
      end else begin
        wdog <= s_ack_i ? '0 : s_stb_o ? wdog + WW'(1) : wdog;
      end
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed self-checking bench for wb_arbiter with four masters and an 8-cycle watchdog
module tb_wb_arbiter;
  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   m_cyc, m_stb, m_we, m_ack, m_err;
  logic [7:0]   m_adr;
  logic [127:0] m_dat;
  logic [15:0]  m_sel;
  logic [31:0]  m_dat_o, s_dat_o, s_dat;
  logic         s_cyc, s_stb, s_we, s_ack;
  logic [1:0]   s_adr;
  logic [3:0]   s_sel;
  int           checks = 0;
  int           errors = 0;
  always #5 clk = ~clk;
  wb_arbiter #(.NM(4), .AW(2), .DW(32), .TMO(8)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .m_cyc_i(m_cyc),
    .m_stb_i(m_stb),
    .m_we_i (m_we),
    .m_adr_i(m_adr),
    .m_dat_i(m_dat),
    .m_sel_i(m_sel),
    .m_ack_o(m_ack),
    .m_err_o(m_err),
    .m_dat_o(m_dat_o),
    .s_cyc_o(s_cyc),
    .s_stb_o(s_stb),
    .s_we_o (s_we),
    .s_adr_o(s_adr),
    .s_dat_o(s_dat_o),
    .s_sel_o(s_sel),
    .s_ack_i(s_ack),
    .s_dat_i(s_dat)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    m_cyc = '0;
    m_stb = '0;
    s_ack = 1'b1;
    @(negedge clk);
    #1 chk("rst_cyc", s_cyc, 0);
    chk("rst_ack", m_ack, 0);
    @(negedge clk);
    rst = 1'b0;
    s_ack = 1'b0;
    #1 chk("rst_after_cyc", s_cyc, 0);
    chk("rst_after_sel", s_sel, 0);
  endtask
  initial begin
    m_we  = 4'b0010;
    m_adr = 8'b11_10_01_00;
    m_sel = 16'h8421;
    m_dat = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
    s_dat = '0;
    do_reset();
    m_cyc = 4'b0001;
    m_stb = 4'b0001;
    #1 chk("grant_latency", s_cyc, 0);
    @(negedge clk);
    #1 chk("m0_grant", s_cyc, 1);
    chk("m0_sel", s_sel, 4'b0001);
    chk("m0_stb", s_stb, 1);
    chk("m0_wdat", s_dat_o, 32'hD0);
    chk("no_early_ack", m_ack, 0);
    @(negedge clk);
    m_stb = 4'b0000;
    s_ack = 1'b1;
    s_dat = 32'h5A00_0000;
    #1 chk("m0_ack", m_ack, 4'b0001);
    chk("rdata", m_dat_o, 32'h5A00_0000);
    @(negedge clk);
    s_ack = 1'b0;
    m_cyc = 4'b0000;
    #1 chk("hold_to_release", s_cyc, 1);
    chk("ack_one_cycle", m_ack, 0);
    @(negedge clk);
    s_ack = 1'b1;
    #1 chk("late_ack_dropped", m_ack, 0);
    chk("released", s_cyc, 0);
    @(negedge clk);
    s_ack = 1'b0;
    do_reset();
    m_cyc = 4'b0011;
    m_stb = 4'b0011;
    for (int t = 0; t < 4; t++) begin
      #1 chk("alt_idle_gap", s_cyc, 0);
      @(negedge clk);
      s_ack = 1'b1;
      m_cyc[t % 2] = 1'b0;
      m_stb[t % 2] = 1'b0;
      #1 chk("alt_grant", s_sel, 4'(1 << (t % 2)));
      chk("alt_ack", m_ack, 4'(1 << (t % 2)));
      @(negedge clk);
      s_ack = 1'b0;
      m_cyc = 4'b0011;
      m_stb = 4'b0011;
    end
    m_cyc = 4'b0010;
    m_stb = 4'b0010;
    @(negedge clk);
    #1 chk("own1_sel", s_sel, 4'b0010);
    chk("own1_we", s_we, 1);
    m_cyc = 4'b0011;
    m_stb = 4'b0011;
    repeat (2) begin
      @(negedge clk);
      #1 chk("no_preempt", s_sel, 4'b0010);
    end
    m_cyc = 4'b0001;
    m_stb = 4'b0001;
    @(negedge clk);
    #1 chk("own1_release", s_cyc, 0);
    @(negedge clk);
    #1 chk("m0_after_m1", s_sel, 4'b0001);
    chk("own0_we", s_we, 0);
    m_cyc = 4'b0000;
    m_stb = 4'b0000;
    @(negedge clk);
    do_reset();
    m_cyc = 4'b1010;
    m_stb = 4'b1010;
    @(negedge clk);
    #1 chk("rr_m1", s_sel, 4'b0010);
    m_cyc = 4'b1000;
    m_stb = 4'b1000;
    @(negedge clk);
    #1 chk("rr_gap", s_cyc, 0);
    m_cyc = 4'b1010;
    m_stb = 4'b1010;
    @(negedge clk);
    #1 chk("rr_m3", s_sel, 4'b1000);
    m_cyc = 4'b0000;
    m_stb = 4'b0000;
    @(negedge clk);
    m_cyc = 4'b0011;
    m_stb = 4'b0011;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      #1 chk("wdog_err", m_err, k == 8 ? 4'b0001 : 4'b0000);
      chk("wdog_busy", s_cyc, 1);
    end
    @(negedge clk);
    #1 chk("tmo_release", s_cyc, 0);
    chk("err_one_cycle", m_err, 0);
    @(negedge clk);
    #1 chk("tmo_next_master", s_sel, 4'b0010);
    m_cyc = 4'b0001;
    m_stb = 4'b0001;
    @(negedge clk);
    #1 chk("m1_release", s_cyc, 0);
    @(negedge clk);
    #1 chk("lockout", s_cyc, 0);
    m_cyc = 4'b0000;
    m_stb = 4'b0000;
    @(negedge clk);
    m_cyc = 4'b0001;
    m_stb = 4'b0001;
    @(negedge clk);
    #1 chk("readmit", s_sel, 4'b0001);
    for (int k = 2; k <= 7; k++) @(negedge clk);
    @(negedge clk);
    s_ack = 1'b1;
    #1 chk("ack_wins_ack", m_ack, 4'b0001);
    chk("ack_wins_err", m_err, 0);
    @(negedge clk);
    s_ack = 1'b0;
    #1 chk("wdog_cleared", m_err, 0);
    chk("still_busy", s_cyc, 1);
    @(negedge clk);
    rst = 1'b1;
    s_ack = 1'b1;
    #1 chk("rst_busy_cyc", s_cyc, 0);
    chk("rst_busy_ack", m_ack, 0);
    chk("rst_busy_err", m_err, 0);
    @(negedge clk);
    rst = 1'b0;
    s_ack = 1'b0;
    m_cyc = 4'b0000;
    m_stb = 4'b0000;
    #1 chk("post_rst_cyc", s_cyc, 0);
    chk("post_rst_ack", m_ack, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
